// File: rtl/glitch_trigger.sv
// glitch_trigger: arms on request, waits for a synchronized edge on trig_in,
// then fires a one-cycle start pulse to a glitch generator, repeating for a
// latched number of shots while sweeping the delay by a fixed step.
module glitch_trigger (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        abort,
    input  logic        trig_in,
    input  logic        edge_sel,
    input  logic [7:0]  width_in,
    input  logic [15:0] delay_in,
    input  logic [15:0] delay_step,
    input  logic [7:0]  mode_in,
    input  logic [7:0]  shots,
    input  logic        glitch_ready,
    output logic [7:0]  width_out,
    output logic [15:0] delay_out,
    output logic [7:0]  mode_out,
    output logic        glitch_start,
    output logic        armed,
    output logic        busy,
    output logic        done,
    output logic [7:0]  shot_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        FIRE   = 3'd2,
        SETTLE = 3'd3,
        WAIT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        s3_q, s3_d;
    logic        edge_sel_q, edge_sel_d;
    logic [7:0]  shots_q, shots_d;
    logic [7:0]  width_q, width_d;
    logic [15:0] delay_q, delay_d;
    logic [7:0]  mode_q, mode_d;
    logic [7:0]  shot_cnt_q, shot_cnt_d;
    logic        start_q, start_d;
    logic        done_q, done_d;

    logic        edge_det;
    logic [7:0]  shot_next;

    // Next-state, synchronizer and output-register logic for the shot sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        edge_sel_d = edge_sel_q;
        shots_d    = shots_q;
        width_d    = width_q;
        delay_d    = delay_q;
        mode_d     = mode_q;
        shot_cnt_d = shot_cnt_q;
        start_d    = 1'b0;
        done_d     = 1'b0;

        // Two flops bring trig_in into the clock domain; the third keeps the
        // previous synchronized level so an edge lasts exactly one cycle.
        s1_d = trig_in;
        s2_d = s1_q;
        s3_d = s2_q;

        edge_det  = edge_sel_q ? (~s2_q & s3_q) : (s2_q & ~s3_q);
        shot_next = shot_cnt_q + 8'd1;

        if (state_q != IDLE && abort) begin
            // Abort wins over everything else; counters and latched outputs hold.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm && !abort && glitch_ready) begin
                        state_d    = ARMED;
                        edge_sel_d = edge_sel;
                        shots_d    = (shots == 8'd0) ? 8'd1 : shots;
                        width_d    = width_in;
                        delay_d    = delay_in;
                        mode_d     = mode_in;
                        shot_cnt_d = 8'd0;
                    end
                end
                ARMED: begin
                    if (edge_det) begin
                        state_d = FIRE;
                        start_d = 1'b1;
                    end
                end
                FIRE:   state_d = SETTLE;
                SETTLE: state_d = WAIT;
                WAIT: begin
                    if (glitch_ready) begin
                        shot_cnt_d = shot_next;
                        if (shot_next == shots_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ARMED;
                            delay_d = delay_q + delay_step;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            edge_sel_q <= 1'b0;
            shots_q    <= 8'd0;
            width_q    <= 8'd0;
            delay_q    <= 16'd0;
            mode_q     <= 8'd0;
            shot_cnt_q <= 8'd0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            edge_sel_q <= edge_sel_d;
            shots_q    <= shots_d;
            width_q    <= width_d;
            delay_q    <= delay_d;
            mode_q     <= mode_d;
            shot_cnt_q <= shot_cnt_d;
            start_q    <= start_d;
            done_q     <= done_d;
        end
    end

    assign width_out    = width_q;
    assign delay_out    = delay_q;
    assign mode_out     = mode_q;
    assign glitch_start = start_q;
    assign done         = done_q;
    assign shot_cnt     = shot_cnt_q;
    assign armed        = (state_q == ARMED);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_glitch_trigger.sv
// Testbench for glitch_trigger: stimulus pushes expected start pulses and
// done pulses into queues; a monitor pops and compares as the DUT emits them.
module tb_glitch_trigger;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        abort;
    logic        trig_in;
    logic        edge_sel;
    logic [7:0]  width_in;
    logic [15:0] delay_in;
    logic [15:0] delay_step;
    logic [7:0]  mode_in;
    logic [7:0]  shots;
    logic        glitch_ready;
    logic [7:0]  width_out;
    logic [15:0] delay_out;
    logic [7:0]  mode_out;
    logic        glitch_start;
    logic        armed;
    logic        busy;
    logic        done;
    logic [7:0]  shot_cnt;

    glitch_trigger dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .abort        (abort),
        .trig_in      (trig_in),
        .edge_sel     (edge_sel),
        .width_in     (width_in),
        .delay_in     (delay_in),
        .delay_step   (delay_step),
        .mode_in      (mode_in),
        .shots        (shots),
        .glitch_ready (glitch_ready),
        .width_out    (width_out),
        .delay_out    (delay_out),
        .mode_out     (mode_out),
        .glitch_start (glitch_start),
        .armed        (armed),
        .busy         (busy),
        .done         (done),
        .shot_cnt     (shot_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] delay;
        logic [7:0]  width;
        logic [7:0]  mode;
        int          cyc;
    } start_t;

    start_t start_q[$];
    int     done_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    // Reference model of the armed sequence
    logic [15:0] m_base;
    logic [15:0] m_step;
    logic [7:0]  m_width;
    logic [7:0]  m_mode;
    logic        m_esel;
    int          m_total;
    int          m_idx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every start and done pulse against the queues
    always @(negedge clk) begin
        start_t e;
        int     d;
        if (glitch_start === 1'b1) begin
            if (start_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got start at cycle %0d expected none", cyc);
            end else begin
                e = start_q.pop_front();
                check("start_delay", 32'(delay_out), 32'(e.delay));
                check("start_width", 32'(width_out), 32'(e.width));
                check("start_mode", 32'(mode_out), 32'(e.mode));
                check("start_cycle", cyc, e.cyc);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                d = done_q.pop_front();
                check("done_shot_cnt", 32'(shot_cnt), d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_glitch_start"}, 32'(glitch_start), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_armed"}, 32'(armed), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_shot_cnt"}, 32'(shot_cnt), 0);
        check({tag, "_width_out"}, 32'(width_out), 0);
        check({tag, "_delay_out"}, 32'(delay_out), 0);
        check({tag, "_mode_out"}, 32'(mode_out), 0);
    endtask

    task automatic do_arm(input logic [7:0] sh, input logic [15:0] d, input logic [15:0] st,
                          input logic [7:0] w, input logic [7:0] md, input logic es);
        shots      = sh;
        delay_in   = d;
        delay_step = st;
        width_in   = w;
        mode_in    = md;
        edge_sel   = es;
        arm        = 1'b1;
        tick(1);
        arm        = 1'b0;
        m_base  = d;
        m_step  = st;
        m_width = w;
        m_mode  = md;
        m_esel  = es;
        m_total = (sh == 8'd0) ? 1 : int'(sh);
        m_idx   = 0;
        // Scramble the live inputs to prove the DUT uses latched copies
        width_in = 8'($urandom);
        mode_in  = 8'($urandom);
        delay_in = 16'($urandom);
        shots    = 8'($urandom);
        edge_sel = 1'($urandom);
    endtask

    // Expected start: delay advances by step per shot (16-bit wrap), pulse
    // appears three clock edges after trig_in changes.
    task automatic push_start();
        start_t e;
        e.delay = m_base + 16'(m_idx) * m_step;
        e.width = m_width;
        e.mode  = m_mode;
        e.cyc   = cyc + 3;
        start_q.push_back(e);
        m_idx++;
        if (m_idx == m_total) done_q.push_back(m_total);
    endtask

    task automatic edge_shot();
        trig_in = ~m_esel;
        push_start();
        tick(8);
        trig_in = m_esel;
        tick(4);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0; edge_sel = 1'b0;
        width_in = 8'd0; delay_in = 16'd0; delay_step = 16'd0; mode_in = 8'd0;
        shots = 8'd0; glitch_ready = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // Single shot, rising edge
        do_arm(8'd1, 16'h0010, 16'h0004, 8'd4, 8'h5A, 1'b0);
        check("single_armed", 32'(armed), 1);
        edge_shot();
        check("single_shot_cnt", 32'(shot_cnt), 1);
        check("single_idle", 32'(busy), 0);

        // Delay sweep over three shots
        do_arm(8'd3, 16'h0100, 16'h0010, 8'd9, 8'h21, 1'b0);
        for (int j = 0; j < 3; j++) edge_shot();
        check("sweep_shot_cnt", 32'(shot_cnt), 3);
        check("sweep_idle", 32'(busy), 0);

        // Zero shots behaves as one; then a two-shot wrap of the delay
        do_arm(8'd0, 16'hFFF0, 16'h0020, 8'd3, 8'h77, 1'b0);
        edge_shot();
        check("zero_shots_cnt", 32'(shot_cnt), 1);
        check("zero_shots_idle", 32'(busy), 0);
        do_arm(8'd2, 16'hFFF0, 16'h0020, 8'd3, 8'h78, 1'b0);
        edge_shot();
        edge_shot();
        check("wrap_delay", 32'(delay_out), 32'h0010);
        check("wrap_shot_cnt", 32'(shot_cnt), 2);

        // Edges during SETTLE/WAIT are ignored and not queued
        do_arm(8'd2, 16'h0200, 16'h0040, 8'd6, 8'h11, 1'b0);
        glitch_ready = 1'b0;
        trig_in = 1'b1;
        push_start();
        tick(4);
        trig_in = 1'b0;
        tick(2);
        trig_in = 1'b1;
        tick(6);
        check("wait_busy", 32'(busy), 1);
        check("wait_not_armed", 32'(armed), 0);
        check("wait_shot_cnt", 32'(shot_cnt), 0);
        glitch_ready = 1'b1;
        tick(8);
        check("rearm_armed", 32'(armed), 1);
        check("rearm_shot_cnt", 32'(shot_cnt), 1);
        trig_in = 1'b0;
        tick(4);
        edge_shot();
        check("ignored_total_cnt", 32'(shot_cnt), 2);

        // Falling-edge select: rising transition must not fire
        trig_in = 1'b0;
        tick(4);
        do_arm(8'd1, 16'h1234, 16'h0001, 8'd2, 8'h42, 1'b1);
        trig_in = 1'b1;
        tick(8);
        check("fall_rise_ignored", 32'(armed), 1);
        trig_in = 1'b0;
        push_start();
        tick(8);
        check("fall_shot_cnt", 32'(shot_cnt), 1);
        check("fall_idle", 32'(busy), 0);

        // Abort in ARMED
        do_arm(8'd1, 16'h0300, 16'h0001, 8'd1, 8'h01, 1'b0);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_armed_busy", 32'(busy), 0);
        check("abort_armed_armed", 32'(armed), 0);
        trig_in = 1'b1;
        tick(6);
        check("idle_edge_busy", 32'(busy), 0);
        trig_in = 1'b0;
        tick(4);

        // Abort in the same cycle as the detected edge
        do_arm(8'd1, 16'h0400, 16'h0001, 8'd1, 8'h02, 1'b0);
        trig_in = 1'b1;
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_edge_busy", 32'(busy), 0);
        tick(6);
        trig_in = 1'b0;
        tick(4);

        // Abort in FIRE: start is kept, outputs held, no done
        do_arm(8'd2, 16'h0500, 16'h0010, 8'd7, 8'h33, 1'b0);
        trig_in = 1'b1;
        push_start();
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_fire_busy", 32'(busy), 0);
        check("abort_fire_shot_cnt", 32'(shot_cnt), 0);
        check("abort_fire_delay", 32'(delay_out), 32'h0500);
        check("abort_fire_width", 32'(width_out), 7);
        trig_in = 1'b0;
        tick(4);

        // Arm and abort together in IDLE
        arm = 1'b1;
        abort = 1'b1;
        tick(1);
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_idle", 32'(busy), 0);

        // Reset mid-WAIT, then arming gated by glitch_ready
        do_arm(8'd2, 16'h0600, 16'h0010, 8'd5, 8'h44, 1'b0);
        glitch_ready = 1'b0;
        trig_in = 1'b1;
        push_start();
        tick(6);
        check("pre_reset_busy", 32'(busy), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_all_zero("rst_mid_wait");
        tick(4);
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        check("arm_not_ready", 32'(busy), 0);
        glitch_ready = 1'b1;
        do_arm(8'd1, 16'h0700, 16'h0001, 8'd1, 8'h01, 1'b0);
        check("arm_after_ready", 32'(armed), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        trig_in = 1'b0;
        tick(4);

        // Randomized sequences against the reference model
        glitch_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic es;
            es = 1'($urandom);
            trig_in = es;
            tick(4);
            do_arm(8'($urandom_range(0, 4)), 16'($urandom), 16'($urandom),
                   8'($urandom), 8'($urandom), es);
            for (int j = 0; j < m_total; j++) edge_shot();
            check("rand_shot_cnt", 32'(shot_cnt), m_total);
            check("rand_idle", 32'(busy), 0);
        end

        tick(5);
        check("start_queue_empty", start_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
